// File: rtl/pio_irq_servicer.sv
// Avalon-MM master that services a PIO edge-capture interrupt: read and clear the
// captured edges, read the data port, queue an event record. Optional PIO_SVC_TIMESTAMP_EN adds evt_time.
module pio_irq_servicer #(
  parameter int               WIDTH      = 10,
  parameter logic [WIDTH-1:0] INIT_MASK  = {WIDTH{1'b1}},
  parameter int               FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pio_irq,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  input  logic             cfg_mask_wr,
  input  logic [WIDTH-1:0] cfg_mask,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_capture,
  output logic [WIDTH-1:0] evt_data,
  output logic [7:0]       evt_seq
`ifdef PIO_SVC_TIMESTAMP_EN
  ,
  output logic [15:0]      evt_time
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [3:0] S_INIT     = 4'd0;
  localparam logic [3:0] S_IDLE     = 4'd1;
  localparam logic [3:0] S_RD_EC    = 4'd2;
  localparam logic [3:0] S_EC_WAIT  = 4'd3;
  localparam logic [3:0] S_CLR      = 4'd4;
  localparam logic [3:0] S_RD_DAT   = 4'd5;
  localparam logic [3:0] S_DAT_WAIT = 4'd6;
  localparam logic [3:0] S_PUSH     = 4'd7;
  localparam logic [3:0] S_MASK_WR  = 4'd8;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MASK = 2'd2;
  localparam logic [1:0] A_EC   = 2'd3;

  typedef struct packed {
`ifdef PIO_SVC_TIMESTAMP_EN
    logic [15:0]      ts;
`endif
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] data;
    logic [7:0]       seq;
  } evt_t;

  logic [3:0]       state, state_nxt;
  logic             run;
  logic [WIDTH-1:0] cap_q, dat_q, mask_pend;
  logic             mask_pend_vld;
  logic [7:0]       seq;
  logic [AW:0]      wr_ptr, rd_ptr;
  evt_t             mem [FIFO_DEPTH];
  evt_t             push_entry, head;
  logic             full, empty, push, pop;
  logic             unused_rd;

  assign unused_rd = ^avm_readdata;

`ifdef PIO_SVC_TIMESTAMP_EN
  logic [15:0] ts_cnt, ts_cap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt <= '0;
      ts_cap <= '0;
    end else begin
      ts_cnt <= ts_cnt + 16'd1;
      if (state == S_EC_WAIT) ts_cap <= ts_cnt;
    end
  end
`endif

  // run holds INIT off the bus for the cycle in which reset is still being released,
  // so the reset-time bus values are idle and the INIT write is exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_INIT;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:     if (run) state_nxt = S_IDLE;
      S_IDLE: begin
        if (mask_pend_vld) state_nxt = S_MASK_WR;
        else if (pio_irq)  state_nxt = S_RD_EC;
      end
      S_RD_EC:    state_nxt = S_EC_WAIT;
      S_EC_WAIT:  state_nxt = (avm_readdata[WIDTH-1:0] == '0) ? S_IDLE : S_CLR;
      S_CLR:      state_nxt = S_RD_DAT;
      S_RD_DAT:   state_nxt = S_DAT_WAIT;
      S_DAT_WAIT: state_nxt = S_PUSH;
      S_PUSH:     if (push) state_nxt = S_IDLE;
      S_MASK_WR:  state_nxt = S_IDLE;
      default:    state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = A_DATA;
    avm_writedata  = '0;
    case (state)
      S_INIT: if (run) begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = A_MASK;
        avm_writedata  = 32'(INIT_MASK);
      end
      S_RD_EC: begin
        avm_chipselect = 1'b1;
        avm_address    = A_EC;
      end
      S_CLR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = A_EC;
        avm_writedata  = 32'(cap_q);
      end
      S_RD_DAT: begin
        avm_chipselect = 1'b1;
        avm_address    = A_DATA;
      end
      S_MASK_WR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = A_MASK;
        avm_writedata  = 32'(mask_pend);
      end
      default: ;
    endcase
  end

  // A request arriving during MASK_WR survives the clear and is applied next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_pend     <= '0;
      mask_pend_vld <= 1'b0;
    end else if (cfg_mask_wr) begin
      mask_pend     <= cfg_mask;
      mask_pend_vld <= 1'b1;
    end else if (state == S_MASK_WR) begin
      mask_pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q <= '0;
      dat_q <= '0;
      seq   <= '0;
    end else begin
      if (state == S_EC_WAIT)  cap_q <= avm_readdata[WIDTH-1:0];
      if (state == S_DAT_WAIT) dat_q <= avm_readdata[WIDTH-1:0];
      if (push)                seq   <= seq + 8'd1;
    end
  end

  // First-word-fall-through queue; a pop frees the slot the same-cycle push uses.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && evt_ready;
  assign push  = (state == S_PUSH) && (!full || pop);

  always_comb begin
    push_entry      = '0;
    push_entry.cap  = cap_q;
    push_entry.data = dat_q;
    push_entry.seq  = seq;
`ifdef PIO_SVC_TIMESTAMP_EN
    push_entry.ts   = ts_cap;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  assign head        = mem[rd_ptr[AW-1:0]];
  assign evt_valid   = !empty;
  assign evt_capture = head.cap;
  assign evt_data    = head.data;
  assign evt_seq     = head.seq;
`ifdef PIO_SVC_TIMESTAMP_EN
  assign evt_time    = head.ts;
`endif

endmodule
